data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 7 +
 rtl/mem_latency_counter.sv | 19 +
 rtl/data_mem_responder.sv | 91 +++++++++
 tb/tb_data_mem_responder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared widths, FSM states and op encoding for the data-memory responder
package data_mem_responder_pkg;
  localparam int DWORD_W = 64;
  localparam int BYTE_OFF_W = 3;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {LOAD, STORE} op_e;
endpackage

// File: rtl/mem_latency_counter.sv
// mem_latency_counter: loadable down-counter (clk, rst active-low sync, load/load_val, en) with terminal flag term (count <= 1)
module mem_latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);
  logic [W-1:0] count_d, count_q;
  always_comb count_d = load ? load_val : (en && count_q != '0) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign term = count_q <= W'(1);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle doubleword memory (Addr/Write_data/MemWrite/MemRead in; ReadData/Stall/Done/Err out), clk, rst active-low sync
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int LATENCY = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DWORD_W-1:0] Addr,
  input  logic [DWORD_W-1:0] Write_data,
  input  logic               MemWrite,
  input  logic               MemRead,
  output logic [DWORD_W-1:0] ReadData,
  output logic               Stall,
  output logic               Done,
  output logic               Err
);
  localparam int CNT_W = $clog2(LATENCY + 1);
  state_e state_d, state_q;
  op_e op_d, op_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [DWORD_W-1:0] wdata_d, wdata_q, rdata_d, rdata_q;
  logic [DWORD_W-1:0] mem_d [DEPTH];
  logic [DWORD_W-1:0] mem_q [DEPTH];
  logic perr_d, perr_q, err_d, err_q;
  logic req, bad_in, cnt_load, cnt_term, to_resp;
  mem_latency_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY - 1)),
    .en       (state_q == BUSY),
    .term     (cnt_term)
  );
  // Both request lines high, misalignment or any address bit above the array all fail the access
  assign bad_in = (MemRead & MemWrite) | (|Addr[BYTE_OFF_W-1:0]) | (|Addr[DWORD_W-1:IDX_W+BYTE_OFF_W]);
  always_comb begin
    req = MemRead | MemWrite;
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    perr_d = perr_q;
    cnt_load = 1'b0;
    if (state_q == IDLE && req) begin
      op_d = MemWrite ? STORE : LOAD;
      idx_d = Addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
      wdata_d = Write_data;
      perr_d = bad_in;
      cnt_load = 1'b1;
      state_d = LATENCY == 1 ? RESP : BUSY;
    end else if (state_q == BUSY && cnt_term) begin
      state_d = RESP;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    // Access uses the _d request fields so a latency-1 access sees the values latched this cycle
    to_resp = state_d == RESP && state_q != RESP;
    mem_d = mem_q;
    if (to_resp && op_d == STORE && !perr_d) mem_d[idx_d] = wdata_d;
    rdata_d = (to_resp && op_d == LOAD) ? (perr_d ? '0 : mem_q[idx_d]) : rdata_q;
    err_d = to_resp ? perr_d : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q <= LOAD;
      idx_q <= '0;
      wdata_q <= '0;
      perr_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      perr_q <= perr_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      mem_q <= mem_d;
    end
  end
  assign Stall = state_q == IDLE ? req : state_q == BUSY;
  assign Done = state_q == RESP;
  assign ReadData = rdata_q;
  assign Err = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: checks four latency builds (1..4) against a transaction-level model plus directed literals
module tb_data_mem_responder;
  logic clk, rst;
  logic [63:0] addr [4], wd [4], rd [4];
  logic mr [4], mw [4], stall [4], done [4], err [4];
  int total = 0, bad = 0;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_responder #(.DEPTH(32), .LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .Addr       (addr[g]),
      .Write_data (wd[g]),
      .MemWrite   (mw[g]),
      .MemRead    (mr[g]),
      .ReadData   (rd[g]),
      .Stall      (stall[g]),
      .Done       (done[g]),
      .Err        (err[g])
    );
  end
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic cmp(string n, int g, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s lat=%0d: got %h want %h", n, g + 1, a, e);
    end
  endtask
  int ph [4];
  bit pl [4], ps [4], pe [4];
  logic [63:0] pa [4], pw [4], erd [4];
  logic [63:0] mm [4][32];
  bit armed = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int g = 0; g < 4; g++) begin
        ph[g] = 0;
        erd[g] = 0;
        for (int i = 0; i < 32; i++) mm[g][i] = 0;
      end
      armed = 1;
    end else if (armed) begin
      for (int g = 0; g < 4; g++) begin
        int lat;
        bit ent;
        lat = g + 1;
        ent = 0;
        cmp("stall", g, stall[g], ph[g] == 0 ? 64'(mr[g] | mw[g]) : 64'(ph[g] < lat));
        cmp("done", g, done[g], 64'(ph[g] == lat));
        cmp("rdata", g, rd[g], erd[g]);
        if (ph[g] == lat) cmp("err", g, err[g], 64'(pe[g]));
        if (ph[g] == 0 && (mr[g] || mw[g])) begin
          pa[g] = addr[g];
          pw[g] = wd[g];
          pl[g] = mr[g] && !mw[g];
          ps[g] = mw[g] && !mr[g];
          pe[g] = (mr[g] && mw[g]) || addr[g][2:0] != 0 || (addr[g] >> 8) != 0;
          ph[g] = 1;
          ent = ph[g] == lat;
        end else if (ph[g] > 0 && ph[g] < lat) begin
          ph[g]++;
          ent = ph[g] == lat;
        end else if (ph[g] == lat) begin
          ph[g] = 0;
        end
        if (ent) begin
          if (pe[g]) begin
            if (pl[g]) erd[g] = 0;
          end else begin
            if (ps[g]) mm[g][pa[g][7:3]] = pw[g];
            if (pl[g]) erd[g] = mm[g][pa[g][7:3]];
          end
        end
      end
    end
  end
  task automatic xact(int g, bit r, bit w, logic [63:0] a, logic [63:0] d, bit xe, logic [63:0] xr, bit cr);
    int n;
    n = 0;
    mr[g] = r; mw[g] = w; addr[g] = a; wd[g] = d;
    @(negedge clk);
    while (!done[g] && n < 20) begin
      n++;
      @(negedge clk);
    end
    cmp("latency", g, 64'(n), 64'(g + 1));
    cmp("err_lit", g, err[g], 64'(xe));
    if (cr) cmp("rdata_lit", g, rd[g], xr);
    @(posedge clk);
    #1;
    mr[g] = 0; mw[g] = 0;
  endtask
  initial begin
    rst = 0;
    for (int g = 0; g < 4; g++) begin
      mr[g] = 0; mw[g] = 0; addr[g] = 0; wd[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1;
    cmp("rst_stall", 1, stall[1], 0);
    cmp("rst_done", 1, done[1], 0);
    cmp("rst_err", 1, err[1], 0);
    cmp("rst_rdata", 1, rd[1], 0);
    xact(1, 1, 0, 64'h10, 0, 0, 0, 1);
    xact(1, 0, 1, 64'h18, 64'hDEADBEEF_CAFEF00D, 0, 0, 0);
    xact(1, 1, 0, 64'h18, 0, 0, 64'hDEADBEEF_CAFEF00D, 1);
    xact(1, 1, 0, 64'h0C, 0, 1, 0, 1);
    xact(1, 0, 1, 64'h100, 64'h77, 1, 0, 0);
    xact(1, 1, 0, 64'h0, 0, 0, 0, 1);
    xact(1, 1, 1, 64'h8, 64'h5, 1, 0, 0);
    xact(1, 1, 0, 64'h8, 0, 0, 0, 1);
    xact(1, 1, 0, 64'h8000_0000_0000_0010, 0, 1, 0, 1);
    xact(0, 1, 0, 64'h18, 0, 0, 0, 1);
    xact(0, 0, 1, 64'h8, 64'h1234, 0, 0, 0);
    xact(0, 1, 0, 64'h8, 0, 0, 64'h1234, 1);
    xact(3, 0, 1, 64'hF8, 64'hA5A5, 0, 0, 0);
    xact(3, 1, 0, 64'hF8, 0, 0, 64'hA5A5, 1);
    xact(3, 1, 0, 64'h100, 0, 1, 0, 1);
    mw[2] = 1; addr[2] = 64'h20; wd[2] = 64'h55;
    @(posedge clk);
    #1;
    cmp("mid_stall", 2, stall[2], 1);
    rst = 0; mw[2] = 0;
    @(posedge clk);
    #1 rst = 1;
    cmp("post_rst_stall", 2, stall[2], 0);
    cmp("post_rst_done", 2, done[2], 0);
    xact(2, 1, 0, 64'h20, 0, 0, 0, 1);
    xact(1, 1, 0, 64'h18, 0, 0, 0, 1);
    xact(3, 1, 0, 64'hF8, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
